// File: rtl/vc_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : vc_arbiter_if
// Purpose  : Bundles the VC-FIFO read side, the destination-FIFO write side
//            and the status outputs of vc_arbiter into one interface.
// Ports    : master - arbiter view (pops, pushes, data_out, counters, idle
//                     are outputs; FIFO flags/data and active are inputs)
//            slave  - environment view (directions mirrored)
// Revision : 1.0 - initial release
// ============================================================================
interface vc_arbiter_if #(
   parameter int DATA_WIDTH = 6
);
   logic                  active;
   logic                  vc0_empty;
   logic                  vc1_empty;
   logic [DATA_WIDTH-1:0] vc0_data;
   logic [DATA_WIDTH-1:0] vc1_data;
   logic                  d0_almost_full;
   logic                  d1_almost_full;
   logic                  vc0_pop;
   logic                  vc1_pop;
   logic                  d0_push;
   logic                  d1_push;
   logic [DATA_WIDTH-1:0] data_out;
   logic [7:0]            fwd_count_d0;
   logic [7:0]            fwd_count_d1;
   logic                  idle;

   modport master (
      input  active, vc0_empty, vc1_empty, vc0_data, vc1_data,
             d0_almost_full, d1_almost_full,
      output vc0_pop, vc1_pop, d0_push, d1_push, data_out,
             fwd_count_d0, fwd_count_d1, idle
   );

   modport slave (
      output active, vc0_empty, vc1_empty, vc0_data, vc1_data,
             d0_almost_full, d1_almost_full,
      input  vc0_pop, vc1_pop, d0_push, d1_push, data_out,
             fwd_count_d0, fwd_count_d1, idle
   );
endinterface
`default_nettype wire

// File: rtl/vc_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vc_arbiter
// Purpose  : Pops words from two virtual-channel FIFOs with weighted priority
//            toward VC0 and routes each word, by its destination bit, into
//            destination FIFO D0 or D1. Pop-to-push latency is two cycles.
// Ports    : clk   - clock, all state on the rising edge
//            reset - synchronous, active-high; discards in-flight words
//            bus   - vc_arbiter_if.master: active, VC empty/data, D
//                    almost-full in; pops (combinational), pushes, data_out,
//                    per-destination counters and idle (registered) out
// Revision : 1.0 - initial release
// ============================================================================
module vc_arbiter #(
   parameter int DATA_WIDTH = 6,
   parameter int DEST_BIT   = 4,
   parameter int VC0_WEIGHT = 3
) (
   input  logic         clk,
   input  logic         reset,
   vc_arbiter_if.master bus
);
   localparam logic [2:0] C_WEIGHT = 3'(VC0_WEIGHT);

   logic                  eligible;
   logic                  grant0;
   logic                  grant1;
   logic [DATA_WIDTH-1:0] word;

   logic [2:0]            wcnt_q,     wcnt_d;
   logic                  s1_valid_q, s1_valid_d;
   logic                  s1_vc_q,    s1_vc_d;
   logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
   logic                  d0_push_q,  d0_push_d;
   logic                  d1_push_q,  d1_push_d;
   logic [7:0]            cnt0_q,     cnt0_d;
   logic [7:0]            cnt1_q,     cnt1_d;
   logic                  idle_q,     idle_d;

   always_comb begin
      // The destination of the next word is unknown until it is read, so
      // either almost-full flag blocks every pop.
      eligible = bus.active & ~reset & ~bus.d0_almost_full & ~bus.d1_almost_full;

      // wcnt never exceeds C_WEIGHT, so "not below the weight" means the
      // VC0 burst is used up and a waiting VC1 takes the grant.
      grant0 = eligible & ~bus.vc0_empty & (bus.vc1_empty | (wcnt_q < C_WEIGHT));
      grant1 = eligible & ~bus.vc1_empty & ~grant0;

      wcnt_d = wcnt_q;
      if (grant1) begin
         wcnt_d = 3'd0;
      end else if (grant0 && (wcnt_q < C_WEIGHT)) begin
         wcnt_d = wcnt_q + 3'd1;
      end

      s1_valid_d = grant0 | grant1;
      s1_vc_d    = grant1;

      // The word popped last cycle is now on the selected FIFO's output.
      word       = s1_vc_q ? bus.vc1_data : bus.vc0_data;
      d0_push_d  = s1_valid_q & ~word[DEST_BIT];
      d1_push_d  = s1_valid_q &  word[DEST_BIT];
      data_out_d = s1_valid_q ? word : data_out_q;

      cnt0_d = cnt0_q + {7'd0, d0_push_q};
      cnt1_d = cnt1_q + {7'd0, d1_push_q};

      idle_d = ~s1_valid_q & ~(d0_push_d | d1_push_d) & bus.vc0_empty & bus.vc1_empty;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wcnt_q     <= 3'd0;
         s1_valid_q <= 1'b0;
         s1_vc_q    <= 1'b0;
         data_out_q <= '0;
         d0_push_q  <= 1'b0;
         d1_push_q  <= 1'b0;
         cnt0_q     <= 8'd0;
         cnt1_q     <= 8'd0;
         idle_q     <= 1'b1;
      end else begin
         wcnt_q     <= wcnt_d;
         s1_valid_q <= s1_valid_d;
         s1_vc_q    <= s1_vc_d;
         data_out_q <= data_out_d;
         d0_push_q  <= d0_push_d;
         d1_push_q  <= d1_push_d;
         cnt0_q     <= cnt0_d;
         cnt1_q     <= cnt1_d;
         idle_q     <= idle_d;
      end
   end

   assign bus.vc0_pop      = grant0;
   assign bus.vc1_pop      = grant1;
   assign bus.d0_push      = d0_push_q;
   assign bus.d1_push      = d1_push_q;
   assign bus.data_out     = data_out_q;
   assign bus.fwd_count_d0 = cnt0_q;
   assign bus.fwd_count_d1 = cnt1_q;
   assign bus.idle         = idle_q;
endmodule
`default_nettype wire

// File: tb/tb_vc_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vc_arbiter
// Purpose  : Self-checking bench for vc_arbiter. Models the two VC FIFOs as
//            queues and keeps a cycle-level reference of the arbitration and
//            forwarding rules; adds a grant-rule vector table and directed
//            multi-cycle sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vc_arbiter;
   localparam int DW = 6;
   localparam int DB = 4;
   localparam int W  = 3;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   vc_arbiter_if #(.DATA_WIDTH(DW)) bus ();

   vc_arbiter #(.DATA_WIDTH(DW), .DEST_BIT(DB), .VC0_WEIGHT(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int tests = 0;
   int fails = 0;

   logic [DW-1:0] q0[$];
   logic [DW-1:0] q1[$];

   // reference state
   int            m_streak;    // VC0 grants since the last VC1 grant, capped at W
   bit            m_v;         // a word was popped last cycle
   logic [DW-1:0] m_w;         // that word
   bit            have_exp = 0;
   bit            e_p0, e_p1, e_idle;
   logic [DW-1:0] e_data;
   int            e_c0, e_c1;

   typedef struct {
      bit act; bit af0; bit af1;
      int n0;  int n1;
      bit p0;  bit p1;
   } vec_t;
   vec_t vecs[8];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference evaluation of one cycle, run mid-cycle with inputs stable.
   task automatic model_step();
      bit ne0, ne1, elig, x0, x1;
      ne0  = !bus.vc0_empty && q0.size() != 0;
      ne1  = !bus.vc1_empty && q1.size() != 0;
      elig = bus.active && !reset && !bus.d0_almost_full && !bus.d1_almost_full;
      x0   = elig && ne0 && (!ne1 || m_streak < W);
      x1   = elig && ne1 && !x0;
      chk("vc0_pop", bus.vc0_pop, x0);
      chk("vc1_pop", bus.vc1_pop, x1);
      if (have_exp) begin
         chk("d0_push", bus.d0_push, e_p0);
         chk("d1_push", bus.d1_push, e_p1);
         chk("data_out", bus.data_out, e_data);
         chk("fwd_count_d0", bus.fwd_count_d0, e_c0);
         chk("fwd_count_d1", bus.fwd_count_d1, e_c1);
         chk("idle", bus.idle, e_idle);
      end
      if (reset) begin
         e_p0 = 0; e_p1 = 0; e_data = '0; e_c0 = 0; e_c1 = 0; e_idle = 1;
         m_v = 0; m_streak = 0;
      end else begin
         e_c0   = (e_c0 + int'(e_p0)) % 256;
         e_c1   = (e_c1 + int'(e_p1)) % 256;
         e_p0   = m_v && !m_w[DB];
         e_p1   = m_v &&  m_w[DB];
         if (m_v) e_data = m_w;
         e_idle = !m_v && !ne0 && !ne1;
         m_v    = x0 || x1;
         if (x0) m_w = q0[0];
         else if (x1) m_w = q1[0];
         if (x1) m_streak = 0;
         else if (x0 && m_streak < W) m_streak++;
      end
      have_exp = 1;
   endtask

   // VC FIFO model: pop on the edge, output register and empty flag update
   // with the edge.
   task automatic fifo_edge();
      if (bus.vc0_pop && q0.size() != 0) bus.vc0_data <= q0.pop_front();
      if (bus.vc1_pop && q1.size() != 0) bus.vc1_data <= q1.pop_front();
      bus.vc0_empty <= (q0.size() == 0);
      bus.vc1_empty <= (q1.size() == 0);
   endtask

   // One clock cycle; returns 1 time unit after the rising edge.
   task automatic cyc();
      @(negedge clk);
      model_step();
      @(posedge clk);
      fifo_edge();
      #1;
   endtask

   task automatic load(input int vc, input int n, input logic [DW-1:0] mask);
      for (int k = 0; k < n; k++) begin
         logic [DW-1:0] w;
         w = DW'($urandom) & mask;
         if (vc == 0) q0.push_back(w); else q1.push_back(w);
      end
   endtask

   // Reset for two cycles; preloaded words are visible when reset falls.
   task automatic do_reset(input int n0, input int n1);
      reset = 1;
      bus.active = 0; bus.d0_almost_full = 0; bus.d1_almost_full = 0;
      q0.delete(); q1.delete();
      cyc();
      load(0, n0, '1);
      load(1, n1, '1);
      cyc();
      reset = 0;
   endtask

   initial begin
      int pushes, late, g, prev;
      bit wrap;
      bus.active = 0; bus.d0_almost_full = 0; bus.d1_almost_full = 0;
      bus.vc0_empty = 1; bus.vc1_empty = 1; bus.vc0_data = '0; bus.vc1_data = '0;

      //           act af0 af1 n0 n1 p0 p1
      vecs[0] = '{1, 0, 0, 1, 1, 1, 0};
      vecs[1] = '{1, 0, 0, 2, 0, 1, 0};
      vecs[2] = '{1, 0, 0, 0, 2, 0, 1};
      vecs[3] = '{1, 0, 0, 0, 0, 0, 0};
      vecs[4] = '{0, 0, 0, 1, 1, 0, 0};
      vecs[5] = '{1, 1, 0, 1, 1, 0, 0};
      vecs[6] = '{1, 0, 1, 1, 0, 0, 0};
      vecs[7] = '{1, 1, 1, 0, 1, 0, 0};

      // reset state
      do_reset(0, 0);
      chk("rst_d0_push", bus.d0_push, 0);
      chk("rst_d1_push", bus.d1_push, 0);
      chk("rst_data_out", bus.data_out, 0);
      chk("rst_cnt0", bus.fwd_count_d0, 0);
      chk("rst_cnt1", bus.fwd_count_d1, 0);
      chk("rst_idle", bus.idle, 1);

      // grant-rule vectors
      for (int i = 0; i < 8; i++) begin
         do_reset(vecs[i].n0, vecs[i].n1);
         bus.active = vecs[i].act;
         bus.d0_almost_full = vecs[i].af0;
         bus.d1_almost_full = vecs[i].af1;
         #1;
         chk($sformatf("vec%0d_pop0", i), bus.vc0_pop, vecs[i].p0);
         chk($sformatf("vec%0d_pop1", i), bus.vc1_pop, vecs[i].p1);
         cyc();
      end

      // two words from VC0, one per destination
      do_reset(0, 0);
      q0.push_back(6'b000101);
      q0.push_back(6'b010110);
      cyc();
      bus.active = 1;
      #1 chk("seq_pop_c0", bus.vc0_pop, 1);
      cyc();
      #1 chk("seq_pop_c1", bus.vc0_pop, 1);
      cyc();
      chk("seq_d0_push_c2", bus.d0_push, 1);
      chk("seq_data_c2", bus.data_out, 6'b000101);
      cyc();
      chk("seq_d1_push_c3", bus.d1_push, 1);
      chk("seq_data_c3", bus.data_out, 6'b010110);
      cyc();
      chk("seq_cnt0", bus.fwd_count_d0, 1);
      chk("seq_cnt1", bus.fwd_count_d1, 1);

      // weighted priority: VC0,VC0,VC0,VC1 repeating
      do_reset(8, 8);
      bus.active = 1;
      for (int i = 0; i < 16; i++) begin
         #1;
         g = bus.vc0_pop ? 0 : (bus.vc1_pop ? 1 : 2);
         chk("wgt_both_pops", bus.vc0_pop & bus.vc1_pop, 0);
         if (i < 8) chk($sformatf("wgt_grant%0d", i), g, (i % 4 == 3) ? 1 : 0);
         cyc();
      end

      // almost-full mid-stream
      do_reset(10, 0);
      bus.active = 1;
      repeat (3) cyc();
      bus.d1_almost_full = 1;
      #1 chk("af_pop_blocked", bus.vc0_pop, 0);
      pushes = int'(bus.d0_push | bus.d1_push);
      late = 0;
      for (int i = 0; i < 7; i++) begin
         cyc();
         pushes += int'(bus.d0_push | bus.d1_push);
         if (i >= 1) late += int'(bus.d0_push | bus.d1_push);
      end
      chk("af_pushes_le2", pushes <= 2, 1);
      chk("af_late_pushes", late, 0);
      bus.d1_almost_full = 0;
      #1 chk("af_pop_resume", bus.vc0_pop, 1);
      cyc();

      // active dropped with two words in flight
      do_reset(2, 0);
      bus.active = 1;
      cyc();
      cyc();
      bus.active = 0;
      load(0, 2, '1);
      pushes = 0;
      for (int i = 0; i < 6; i++) begin
         #1 chk("act_no_pop", bus.vc0_pop | bus.vc1_pop, 0);
         pushes += int'(bus.d0_push | bus.d1_push);
         cyc();
      end
      chk("act_inflight_pushes", pushes, 2);
      chk("act_not_idle", bus.idle, 0);
      bus.active = 1;
      repeat (8) cyc();
      chk("act_idle_drained", bus.idle, 1);

      // reset pulse during a stream
      do_reset(12, 12);
      bus.active = 1;
      repeat (5) cyc();
      reset = 1;
      #1 chk("rstm_pops_low", bus.vc0_pop | bus.vc1_pop, 0);
      cyc();
      reset = 0;
      chk("rstm_no_push", bus.d0_push | bus.d1_push, 0);
      chk("rstm_cnt0", bus.fwd_count_d0, 0);
      chk("rstm_cnt1", bus.fwd_count_d1, 0);
      for (int i = 0; i < 4; i++) begin
         #1;
         g = bus.vc0_pop ? 0 : (bus.vc1_pop ? 1 : 2);
         chk($sformatf("rstm_grant%0d", i), g, (i == 3) ? 1 : 0);
         cyc();
      end

      // randomized traffic against the reference
      do_reset(0, 0);
      for (int i = 0; i < 1500; i++) begin
         if (q0.size() < 16 && $urandom_range(0, 2) == 0) load(0, 1, '1);
         if (q1.size() < 16 && $urandom_range(0, 2) == 0) load(1, 1, '1);
         bus.active = ($urandom_range(0, 15) != 0);
         if ($urandom_range(0, 9) == 0) bus.d0_almost_full = ~bus.d0_almost_full;
         if ($urandom_range(0, 9) == 0) bus.d1_almost_full = ~bus.d1_almost_full;
         reset = ($urandom_range(0, 199) == 0);
         cyc();
      end

      // 300 words to D0: counter wraps
      do_reset(0, 0);
      load(0, 300, 6'b101111);
      cyc();
      bus.active = 1;
      wrap = 0;
      for (int i = 0; i < 400; i++) begin
         prev = int'(bus.fwd_count_d0);
         cyc();
         if (prev == 255 && bus.fwd_count_d0 == 8'd0) wrap = 1;
      end
      chk("wrap_seen", wrap, 1);
      chk("wrap_cnt0", bus.fwd_count_d0, 44);
      chk("wrap_cnt1", bus.fwd_count_d1, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
`default_nettype wire
